msk_and_hpc3_lanes: RTL and testbench



---
 rtl/msk_and_hpc3_lanes.sv | 151 +++++++++++++++
 tb/tb_msk_and_hpc3_lanes.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_hpc3_lanes.sv
// Multi-lane HPC3 masked AND with valid/ready on both sides and an operand-swap mode.
// Define MSK_AND_SKID_EN to add a one-entry skid register so in_ready ignores out_ready.
module msk_and_hpc3_lanes #(
    parameter int d = 2,
    parameter int W = 1,
    localparam int NP = d * (d - 1) / 2,
    localparam int RW = W * 2 * NP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_swap,
    input  logic [W*d-1:0]  ina,
    input  logic [W*d-1:0]  inb,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    input  logic [RW-1:0]   rnd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*d-1:0]  out,
    output logic            out_swap,
    output logic [15:0]     xfer_cnt
);

    typedef logic [W-1:0][d-1:0][d-1:0] term_t;

    // Diagonal of termU holds p_ii and diagonal of termV is zero, so every share
    // reduces to one uniform XOR across its row.
    term_t          termUCalc;
    term_t          termVCalc;
    term_t          termU_q;
    term_t          termV_q;
    logic           swap_q;
    logic           valid_q;
    logic           valid_d;
    logic [15:0]    cnt_q;
    logic [15:0]    cnt_d;
    logic [W*d-1:0] opX;
    logic [W*d-1:0] opY;
    logic [W*d-1:0] stageShares;
    logic           accept;
    logic           outFire;
    int             pairK;
    logic           rK;
    logic           rpK;

    assign accept    = in_valid & rnd_valid & in_ready;
    assign rnd_ready = accept;
    assign outFire   = out_valid & out_ready;
    assign opX       = in_swap ? inb : ina;
    assign opY       = in_swap ? ina : inb;

    always_comb begin
        termUCalc = '0;
        termVCalc = '0;
        pairK     = 0;
        rK        = 1'b0;
        rpK       = 1'b0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                termUCalc[l][i][i] = opX[l*d+i] & opY[l*d+i];
            end
            pairK = 0;
            for (int i = 0; i < d; i++) begin
                for (int j = i + 1; j < d; j++) begin
                    rK  = rnd[l*2*NP + pairK];
                    rpK = rnd[l*2*NP + NP + pairK];
                    termUCalc[l][i][j] = opX[l*d+i] & (opY[l*d+j] ^ rK);
                    termVCalc[l][i][j] = (~opX[l*d+i] & rK) ^ rpK;
                    termUCalc[l][j][i] = opX[l*d+j] & (opY[l*d+i] ^ rK);
                    termVCalc[l][j][i] = (~opX[l*d+j] & rK) ^ rpK;
                    pairK = pairK + 1;
                end
            end
        end
    end

    // Share recombination happens only after the stage registers.
    always_comb begin
        stageShares = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                stageShares[l*d+i] = ^(termU_q[l][i] ^ termV_q[l][i]);
            end
        end
    end

    assign cnt_d    = accept ? cnt_q + 16'd1 : cnt_q;
    assign xfer_cnt = cnt_q;

`ifdef MSK_AND_SKID_EN
    logic [W*d-1:0] skid_q;
    logic           skidSwap_q;
    logic           skidFull_q;
    logic           skidFull_d;
    logic           skidLoad;

    // A word arriving while the head is stalled pushes the older head into the skid,
    // so the skid (when full) is always the older entry and is presented first.
    always_comb begin
        skidLoad   = accept & valid_q & ~outFire;
        skidFull_d = skidFull_q ? ~outFire : skidLoad;
        valid_d    = accept | (valid_q & ~(outFire & ~skidFull_q));
    end

    assign in_ready  = ~rst & ~skidFull_q;
    assign out_valid = valid_q;
    assign out       = skidFull_q ? skid_q : stageShares;
    assign out_swap  = skidFull_q ? skidSwap_q : swap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q     <= '0;
            skidSwap_q <= 1'b0;
            skidFull_q <= 1'b0;
        end else begin
            if (skidLoad) begin
                skid_q     <= stageShares;
                skidSwap_q <= swap_q;
            end
            skidFull_q <= skidFull_d;
        end
    end
`else
    assign valid_d   = accept | (valid_q & ~out_ready);
    assign in_ready  = ~rst & (~valid_q | out_ready);
    assign out_valid = valid_q;
    assign out       = stageShares;
    assign out_swap  = swap_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            termU_q <= '0;
            termV_q <= '0;
            swap_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            if (accept) begin
                termU_q <= termUCalc;
                termV_q <= termVCalc;
                swap_q  <= in_swap;
            end
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_msk_and_hpc3_lanes.sv
// Scoreboard bench for msk_and_hpc3_lanes: random sharings checked against a share-level model.
// Builds with or without MSK_AND_SKID_EN; only the backpressure capacity differs.
module tb_msk_and_hpc3_lanes;

    localparam int D  = 3;
    localparam int W  = 4;
    localparam int NP = D * (D - 1) / 2;
    localparam int RW = W * 2 * NP;
    localparam int WD = W * D;
`ifdef MSK_AND_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [WD-1:0] expOut;
        logic          expSwap;
        logic [W-1:0]  expPlain;
        int            acceptCyc;
        bit            latChk;
    } expEntry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid = 1'b0;
    logic          inReady;
    logic          inSwap = 1'b0;
    logic [WD-1:0] inA = '0;
    logic [WD-1:0] inB = '0;
    logic          rndValid = 1'b0;
    logic          rndReady;
    logic [RW-1:0] rndW = '0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [WD-1:0] outData;
    logic          outSwap;
    logic [15:0]   xferCnt;

    expEntry_t     sbQueue[$];
    expEntry_t     monEntry;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [15:0]   modelCnt = 16'd0;

    msk_and_hpc3_lanes #(.d(D), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady), .in_swap(inSwap),
        .ina(inA), .inb(inB),
        .rnd_valid(rndValid), .rnd_ready(rndReady), .rnd(rndW),
        .out_valid(outValid), .out_ready(outReady),
        .out(outData), .out_swap(outSwap), .xfer_cnt(xferCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WD-1:0] shareWord(input logic [W-1:0] plain);
        logic [WD-1:0] w;
        logic [D-1:0]  s;
        w = '0;
        for (int l = 0; l < W; l++) begin
            s = D'($urandom);
            s[D-1] = (^s[D-2:0]) ^ plain[l];
            w[l*D +: D] = s;
        end
        return w;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [WD-1:0] w);
        logic [W-1:0] p;
        for (int l = 0; l < W; l++) p[l] = ^w[l*D +: D];
        return p;
    endfunction

    // Each output share equals x_i AND (parity of y) masked by every r/r' pair touching share i.
    function automatic logic [WD-1:0] modelOut(input logic [WD-1:0] a, input logic [WD-1:0] b,
                                               input logic sw, input logic [RW-1:0] r);
        logic [WD-1:0] e;
        logic [D-1:0]  x;
        logic [D-1:0]  y;
        logic          ri;
        int            k;
        e = '0;
        for (int l = 0; l < W; l++) begin
            x = sw ? b[l*D +: D] : a[l*D +: D];
            y = sw ? a[l*D +: D] : b[l*D +: D];
            for (int i = 0; i < D; i++) begin
                ri = 1'b0;
                k  = 0;
                for (int p = 0; p < D; p++) begin
                    for (int q = p + 1; q < D; q++) begin
                        if (p == i || q == i) ri = ri ^ r[l*2*NP + k] ^ r[l*2*NP + NP + k];
                        k++;
                    end
                end
                e[l*D+i] = (x[i] & (^y)) ^ ri;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [WD-1:0] a, input logic [WD-1:0] b, input logic sw,
                                input logic [RW-1:0] r, input bit latChk);
        expEntry_t e;
        e.expOut    = modelOut(a, b, sw, r);
        e.expSwap   = sw;
        e.expPlain  = unmask(a) & unmask(b);
        e.acceptCyc = cyc;
        e.latChk    = latChk;
        sbQueue.push_back(e);
        modelCnt++;
    endtask

    // Called right after a falling edge; returns on the falling edge after the accept.
    task automatic applyStimulus(input logic [W-1:0] xp, input logic [W-1:0] yp,
                                 input logic sw, input bit latChk);
        int budget;
        budget   = 0;
        inA      = shareWord(xp);
        inB      = shareWord(yp);
        inSwap   = sw;
        rndW     = RW'($urandom);
        inValid  = 1'b1;
        rndValid = 1'b1;
        #1;
        while (!inReady) begin
            if (budget > 50) begin
                checkOutput("acceptTimeout", 32'd0, 32'd1);
                inValid  = 1'b0;
                rndValid = 1'b0;
                return;
            end
            budget++;
            @(negedge clk);
            #1;
        end
        checkOutput("rndReady", {31'd0, rndReady}, 32'd1);
        pushExpected(inA, inB, sw, rndW, latChk);
        @(negedge clk);
        inValid  = 1'b0;
        rndValid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (sbQueue.size() != 0 && budget < 50) begin
            @(negedge clk);
            #3;
            budget++;
        end
        if (sbQueue.size() != 0) checkOutput("drainTimeout", sbQueue.size(), 32'd0);
        @(negedge clk);
    endtask

    // Offers a fresh word every cycle for 5 cycles with out_ready low.
    task automatic stallFill();
        int            accepted;
        bit            haveSnap;
        logic [WD-1:0] snapOut;
        logic          snapSwap;
        accepted = 0;
        haveSnap = 0;
        snapOut  = '0;
        snapSwap = 1'b0;
        outReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            inA      = shareWord(W'($urandom));
            inB      = shareWord(W'($urandom));
            inSwap   = 1'($urandom);
            rndW     = RW'($urandom);
            inValid  = 1'b1;
            rndValid = 1'b1;
            #1;
            if (inReady) begin
                pushExpected(inA, inB, inSwap, rndW, 1'b0);
                accepted++;
            end
            #1;
            if (haveSnap) begin
                checkOutput("stallOut", 32'(outData), 32'(snapOut));
                checkOutput("stallSwap", {31'd0, outSwap}, {31'd0, snapSwap});
            end else if (outValid) begin
                snapOut  = outData;
                snapSwap = outSwap;
                haveSnap = 1;
            end
            @(negedge clk);
        end
        inValid  = 1'b0;
        rndValid = 1'b0;
        #1;
        checkOutput("bpAccepted", accepted, CAP);
        checkOutput("bpInReady", {31'd0, inReady}, 32'd0);
        checkOutput("bpOutValid", {31'd0, outValid}, 32'd1);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && outValid && outReady) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedOut", 32'd1, 32'd0);
            end else begin
                monEntry = sbQueue.pop_front();
                checkOutput("outShares", 32'(outData), 32'(monEntry.expOut));
                checkOutput("outPlain", 32'(unmask(outData)), 32'(monEntry.expPlain));
                checkOutput("outSwap", {31'd0, outSwap}, {31'd0, monEntry.expSwap});
                if (monEntry.latChk) checkOutput("latency", cyc, monEntry.acceptCyc + 1);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        inValid  = 1'b1;
        rndValid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstOutValid", {31'd0, outValid}, 32'd0);
        checkOutput("rstOut", 32'(outData), 32'd0);
        checkOutput("rstOutSwap", {31'd0, outSwap}, 32'd0);
        checkOutput("rstXferCnt", 32'(xferCnt), 32'd0);
        checkOutput("rstInReady", {31'd0, inReady}, 32'd0);
        checkOutput("rstRndReady", {31'd0, rndReady}, 32'd0);
        rst      = 1'b0;
        inValid  = 1'b0;
        rndValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idleInReady", {31'd0, inReady}, 32'd1);
        @(negedge clk);

        // Operand present without randomness: nothing may be taken.
        inA      = shareWord(W'($urandom));
        inB      = shareWord(W'($urandom));
        inSwap   = 1'b0;
        rndW     = RW'($urandom);
        inValid  = 1'b1;
        rndValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("rndReadyStall", {31'd0, rndReady}, 32'd0);
            @(negedge clk);
        end
        checkOutput("xferCntStall", 32'(xferCnt), 32'd0);
        rndValid = 1'b1;
        #1;
        checkOutput("rndReadyPulse", {31'd0, rndReady}, 32'd1);
        pushExpected(inA, inB, inSwap, rndW, 1'b1);
        @(negedge clk);
        inValid  = 1'b0;
        rndValid = 1'b0;
        #1;
        checkOutput("rndReadyAfter", {31'd0, rndReady}, 32'd0);
        checkOutput("xferCntStep", 32'(xferCnt), 32'd1);
        @(negedge clk);

        for (int n = 0; n < 20; n++) applyStimulus('1, '1, 1'($urandom), 1'b1);
        for (int n = 0; n < 20; n++) applyStimulus('1, '0, 1'($urandom), 1'b1);
        for (int n = 0; n < 200; n++) applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        applyStimulus('1, '0, 1'b1, 1'b1);
        applyStimulus('0, '1, 1'b1, 1'b1);
        waitDrain();

        stallFill();
        outReady = 1'b1;
        waitDrain();

        // Reset while results are pending: they are discarded, never handed over.
        stallFill();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRstOutValid", {31'd0, outValid}, 32'd0);
        checkOutput("midRstOut", 32'(outData), 32'd0);
        checkOutput("midRstXferCnt", 32'(xferCnt), 32'd0);
        checkOutput("midRstInReady", {31'd0, inReady}, 32'd0);
        sbQueue.delete();
        modelCnt = 16'd0;
        rst      = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        applyStimulus('1, '1, 1'b0, 1'b1);
        checkOutput("postRstXferCnt", 32'(xferCnt), 32'd1);
        waitDrain();

        for (int n = 0; n < 70000; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            if (modelCnt == 16'hFFFF || modelCnt == 16'h0000)
                checkOutput("xferCntWrap", 32'(xferCnt), 32'(modelCnt));
        end
        waitDrain();
        checkOutput("xferCntFinal", 32'(xferCnt), 32'(modelCnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
